// File: rtl/entrada_botones_if.sv
// ============================================================================
//  Module      : entrada_botones_if
//  Description : Button-side bundle for the input conditioning stage. It carries
//                the four raw push-buttons in and the action pulses and
//                test-mode levels out.
//                master : drives the raw buttons and receives the conditioned outputs
//                slave  : the conditioning stage itself
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface entrada_botones_if;
  logic btn_comer_raw;
  logic btn_jugar_raw;
  logic btn_descansar_raw;
  logic btn_test_raw;
  logic comer;
  logic jugar;
  logic descansar;
  logic test;
  logic acelerar;

  modport master (
    output btn_comer_raw, btn_jugar_raw, btn_descansar_raw, btn_test_raw,
    input  comer, jugar, descansar, test, acelerar
  );

  modport slave (
    input  btn_comer_raw, btn_jugar_raw, btn_descansar_raw, btn_test_raw,
    output comer, jugar, descansar, test, acelerar
  );
endinterface

`default_nettype wire

// File: rtl/entrada_botones.sv
// ============================================================================
//  Module      : entrada_botones
//  Description : Input conditioning for the pet FSM. It synchronises and
//                debounces four raw buttons. It emits one-cycle, priority-
//                arbitrated action pulses (comer > jugar > descansar). A long
//                press on the test button toggles test mode.
//  Ports       : clk  - system clock
//                rst  - synchronous reset, active-high
//                io   - entrada_botones_if.slave (raw buttons in; comer, jugar,
//                       descansar pulses and test/acelerar levels out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module entrada_botones #(
  parameter int DEB_CYCLES  = 50000,
  parameter int HOLD_CYCLES = 250000000,
  parameter int DEB_W       = 16,
  parameter int HOLD_W      = 28
) (
  input  wire logic          clk,
  input  wire logic          rst,
  entrada_botones_if.slave   io
);

  localparam logic [DEB_W-1:0]  c_deb_last  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] c_hold_max  = HOLD_W'(HOLD_CYCLES);

  // Bit order: [0]=comer, [1]=jugar, [2]=descansar, [3]=test
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_stable;
  logic [2:0] r_stable_d;
  logic [2:0] w_rise;

  assign w_raw = {io.btn_test_raw, io.btn_descansar_raw, io.btn_jugar_raw, io.btn_comer_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The counter only runs while the synchronised level disagrees with the
  // accepted level. Any agreeing sample restarts it, so a glitch shorter than
  // DEB_CYCLES never reaches the stable level.
  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    logic [DEB_W-1:0] r_cnt;
    logic             r_stable;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (r_sync2[gi] != r_stable) begin
        if (r_cnt == c_deb_last) begin
          r_stable <= r_sync2[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_stable[gi] = r_stable;
  end

  // Rising edges of the action buttons. Simultaneous edges are resolved by
  // fixed priority, and the losers are dropped.
  assign w_rise = w_stable[2:0] & ~r_stable_d;

  logic r_comer;
  logic r_jugar;
  logic r_descansar;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable_d  <= '0;
      r_comer     <= 1'b0;
      r_jugar     <= 1'b0;
      r_descansar <= 1'b0;
    end else begin
      r_stable_d  <= w_stable[2:0];
      r_comer     <= w_rise[0];
      r_jugar     <= w_rise[1] & ~w_rise[0];
      r_descansar <= w_rise[2] & ~w_rise[1] & ~w_rise[0];
    end
  end

  // Test-mode FSM driven by the debounced test level.
  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_COUNT = 2'd1,
    T_DONE  = 2'd2
  } t_state_e;

  t_state_e          r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_test_mode;
  logic              r_test;
  logic              r_acelerar;
  logic              w_tst;

  assign w_tst = w_stable[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= T_IDLE;
      r_hold_cnt  <= '0;
      r_test_mode <= 1'b0;
      r_test      <= 1'b0;
      r_acelerar  <= 1'b0;
    end else begin
      // Outputs trail test_mode by one cycle.
      r_test     <= r_test_mode;
      r_acelerar <= r_test_mode;
      case (r_state)
        T_IDLE: begin
          if (w_tst) begin
            r_state    <= T_COUNT;
            r_hold_cnt <= HOLD_W'(1);
          end
        end
        T_COUNT: begin
          if (!w_tst) begin
            r_state    <= T_IDLE;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == c_hold_last) begin
            // The count reaches HOLD_CYCLES here and then saturates in T_DONE.
            r_hold_cnt  <= c_hold_max;
            r_test_mode <= ~r_test_mode;
            r_state     <= T_DONE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        T_DONE: begin
          if (!w_tst) begin
            r_state    <= T_IDLE;
            r_hold_cnt <= '0;
          end
        end
        default: begin
          r_state    <= T_IDLE;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  assign io.comer     = r_comer;
  assign io.jugar     = r_jugar;
  assign io.descansar = r_descansar;
  assign io.test      = r_test;
  assign io.acelerar  = r_acelerar;

endmodule

`default_nettype wire

// File: tb/tb_entrada_botones.sv
// ============================================================================
//  Module      : tb_entrada_botones
//  Description : Self-checking bench for entrada_botones with DEB_CYCLES=4 and
//                HOLD_CYCLES=10. A behavioural model predicts every output in
//                every cycle. Each scenario also checks its own expected pulse
//                counts and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_entrada_botones;

  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'b0000;   // [0]=comer [1]=jugar [2]=descansar [3]=test
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  entrada_botones_if bus ();

  assign bus.btn_comer_raw     = raw[0];
  assign bus.btn_jugar_raw     = raw[1];
  assign bus.btn_descansar_raw = raw[2];
  assign bus.btn_test_raw      = raw[3];

  entrada_botones #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD),
    .DEB_W      (16),
    .HOLD_W     (28)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  logic [4:0] obs;
  assign obs = {bus.comer, bus.jugar, bus.descansar, bus.test, bus.acelerar};

  // ---------------- behavioural model ----------------
  // The button seen by the debouncer is the raw input two samples ago. A level
  // is accepted once DEB consecutive samples (since reset or the last change)
  // all show the opposite of the accepted level. A press is reported one cycle
  // after acceptance. Test mode flips when the accepted test level has been
  // high for exactly HOLD consecutive samples.
  logic [1:0]     m_dly [4];
  logic [DEB-1:0] m_hist[4];
  int             m_since[4];
  logic [3:0]     m_acc, m_acc_old;
  int             m_hold;
  logic           m_mode;
  logic [4:0]     m_out;

  task automatic model_step();
    logic [2:0] rise;
    logic       s;
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        m_dly[b] = '0; m_hist[b] = '0; m_since[b] = 0;
      end
      m_acc = '0; m_acc_old = '0; m_hold = 0; m_mode = 1'b0; m_out = '0;
      return;
    end
    rise = m_acc[2:0] & ~m_acc_old[2:0];
    m_out[4] = rise[0];
    m_out[3] = rise[1] && !rise[0];
    m_out[2] = rise[2] && !rise[1] && !rise[0];
    m_out[1] = m_mode;
    m_out[0] = m_mode;
    if (m_acc[3]) begin
      if (m_hold < HOLD) begin
        m_hold++;
        if (m_hold == HOLD) m_mode = ~m_mode;
      end
    end else begin
      m_hold = 0;
    end
    m_acc_old = m_acc;
    for (int b = 0; b < 4; b++) begin
      s = m_dly[b][1];
      m_dly[b] = {m_dly[b][0], raw[b]};
      m_hist[b] = {m_hist[b][DEB-2:0], s};
      m_since[b]++;
      if (m_since[b] >= DEB && m_hist[b] == {DEB{~m_acc[b]}}) begin
        m_acc[b]   = s;
        m_since[b] = 0;
      end
    end
  endtask

  // Drive one cycle of stimulus, let the edge happen, advance the model.
  task automatic cycle(input logic [3:0] r, input logic rs);
    @(negedge clk);
    raw = r;
    rst = rs;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000, 1'b1);
      total++;
      if (obs !== 5'b00000) begin
        bad++; $display("FAIL reset cyc=%0d got=%b want=00000", i, obs);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0000, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs, m_out);
      end
    end
  endtask

  task automatic test_bounce();
    int n_pulse = 0;
    int at = -1;
    for (int i = 0; i < 40; i++) begin
      cycle((i < 20) ? {3'b000, ((i / 2) % 2 == 0)} : 4'b0001, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL bounce cyc=%0d got=%b want=%b", i, obs, m_out);
      end
      if (bus.comer) begin n_pulse++; at = i; end
    end
    total++;
    if (n_pulse != 1 || at != 26) begin
      bad++; $display("FAIL bounce_pulse count=%0d at=%0d want count=1 at=26", n_pulse, at);
    end
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0000, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL bounce_rel cyc=%0d got=%b want=%b", i, obs, m_out);
      end
    end
  endtask

  task automatic test_hold_release();
    int n_pulse = 0;
    for (int i = 0; i < 70; i++) begin
      cycle((i < 50) ? 4'b0010 : 4'b0000, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL hold cyc=%0d got=%b want=%b", i, obs, m_out);
      end
      if (bus.jugar) n_pulse++;
    end
    total++;
    if (n_pulse != 1) begin
      bad++; $display("FAIL hold_pulses got=%0d want=1", n_pulse);
    end
  endtask

  task automatic test_simultaneous();
    int nc = 0, nj = 0, nd = 0;
    for (int i = 0; i < 30; i++) begin
      cycle((i < 15) ? 4'b0110 : 4'b0000, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL simul2 cyc=%0d got=%b want=%b", i, obs, m_out);
      end
      nj += int'(bus.jugar); nd += int'(bus.descansar); nc += int'(bus.comer);
    end
    total++;
    if (nc != 0 || nj != 1 || nd != 0) begin
      bad++; $display("FAIL simul2_pulses c/j/d=%0d/%0d/%0d want 0/1/0", nc, nj, nd);
    end
    nc = 0; nj = 0; nd = 0;
    for (int i = 0; i < 30; i++) begin
      cycle((i < 15) ? 4'b0111 : 4'b0000, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL simul3 cyc=%0d got=%b want=%b", i, obs, m_out);
      end
      nj += int'(bus.jugar); nd += int'(bus.descansar); nc += int'(bus.comer);
    end
    total++;
    if (nc != 1 || nj != 0 || nd != 0) begin
      bad++; $display("FAIL simul3_pulses c/j/d=%0d/%0d/%0d want 1/0/0", nc, nj, nd);
    end
  endtask

  task automatic test_long_press();
    int rises = 0;
    logic prev = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      rises = 0;
      for (int i = 0; i < 50; i++) begin
        cycle((i < 30) ? 4'b1000 : 4'b0000, 1'b0);
        total++;
        if (obs !== m_out) begin
          bad++; $display("FAIL long p=%0d cyc=%0d got=%b want=%b", pass, i, obs, m_out);
        end
        if (bus.test != prev) rises++;
        prev = bus.test;
      end
      total++;
      if (rises != 1 || bus.test !== (pass == 0) || bus.acelerar !== (pass == 0)) begin
        bad++; $display("FAIL long_toggle p=%0d changes=%0d test=%b acel=%b want changes=1 test=%0d",
                        pass, rises, bus.test, bus.acelerar, pass == 0);
      end
    end
  endtask

  task automatic test_short_press();
    for (int i = 0; i < 30; i++) begin
      cycle((i < 8) ? 4'b1000 : 4'b0000, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL short cyc=%0d got=%b want=%b", i, obs, m_out);
      end
    end
    total++;
    if (bus.test !== 1'b0) begin
      bad++; $display("FAIL short_no_toggle test=%b want=0", bus.test);
    end
    for (int i = 0; i < 40; i++) begin
      cycle((i < 20) ? 4'b1000 : 4'b0000, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL repress cyc=%0d got=%b want=%b", i, obs, m_out);
      end
    end
    total++;
    if (bus.test !== 1'b1 || bus.acelerar !== 1'b1) begin
      bad++; $display("FAIL repress_toggle test=%b acel=%b want=1/1", bus.test, bus.acelerar);
    end
  endtask

  task automatic test_reset_mid();
    int at = -1;
    // Four cycles with comer held: the debounce counter is now at 2.
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0001, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL rstmid_pre cyc=%0d got=%b want=%b", i, obs, m_out);
      end
    end
    cycle(4'b0001, 1'b1);
    total++;
    if (obs !== 5'b00000) begin
      bad++; $display("FAIL rstmid_clear got=%b want=00000", obs);
    end
    for (int i = 1; i <= 12; i++) begin
      cycle(4'b0001, 1'b0);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL rstmid_post cyc=%0d got=%b want=%b", i, obs, m_out);
      end
      if (bus.comer) at = i;
    end
    total++;
    if (at != 7) begin
      bad++; $display("FAIL rstmid_pulse at=%0d want=7", at);
    end
    for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0);
  endtask

  task automatic test_random();
    int         left[4];
    logic [3:0] r = 4'b0000;
    logic       rs;
    for (int b = 0; b < 4; b++) left[b] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (left[b] == 0) begin
          r[b]    = 1'($urandom_range(0, 1));
          left[b] = (b == 3) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 9));
        end
        left[b]--;
      end
      rs = ($urandom_range(0, 199) == 0);
      cycle(r, rs);
      total++;
      if (obs !== m_out) begin
        bad++; $display("FAIL random cyc=%0d raw=%b rst=%b got=%b want=%b", i, r, rs, obs, m_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_hold_release();
    test_simultaneous();
    test_long_press();
    test_short_press();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
